pm_loader: RTL
==============

// Module: pm_loader
// PURPOSE
//  Boot-time program-memory writer: the write side of the PM interface that the
//  core's program sequencer only reads. Receives a byte stream from a host over a
//  valid/ready handshake and assembles PMD_SIZE-bit instruction words. Writes them
//  to consecutive PM addresses and verifies a trailing XOR checksum.
//  Holds the core stalled (ld_stallb=0) for the whole load.
// PARAMETERS
//  PMA_SIZE   16   PM address width; must be a multiple of IN_WIDTH
//  PMD_SIZE   32   PM word width; must be a multiple of IN_WIDTH
//  IN_WIDTH    8   host stream width
//  PM_BASE     0   PM address of the first loaded word
// PORTS
//  clk         in   1         core clock
//  reset       in   1         synchronous, active-high
//  ld_start    in   1         begin a load; sampled only in IDLE
//  host_dt     in   IN_WIDTH  stream data, MSB-first within each field
//  host_valid  in   1         host_dt valid
//  host_ready  out  1         loader accepts host_dt this cycle
//  ld_pm_cslt  out  1         PM chip select (1 = access)
//  ld_pm_wrb   out  1         PM write strobe, active-low
//  ld_pm_add   out  PMA_SIZE  PM write address
//  ld_pm_dt    out  PMD_SIZE  PM write data
//  ld_stallb   out  1         0 = core held in stall
//  ld_busy     out  1         load in progress
//  ld_done     out  1         one-cycle pulse at end of load
//  ld_err      out  1         checksum mismatch; sticky until next ld_start
// BEHAVIOUR
//  Reset values: host_ready=0, cslt=0, wrb=1, add=0, dt=0, stallb=1, busy=0,
//   done=0, err=0. FSM goes to IDLE.
//  Reset mid-load abandons the load and restores these values in the next cycle.
//   Words already written stay in PM.
//  Transfer: a beat is accepted when host_valid && host_ready on the same clk edge.
//   host_ready is registered. It is 1 only in HDR, DATA and CHK.
//  FSM:
//   IDLE : ld_start=1 -> HDR. Clear err, checksum, index and count.
//          Set busy=1, stallb=0.
//   HDR  : accept PMA_SIZE/IN_WIDTH beats, MSB first, into count.
//          After the last beat: count==0 -> CHK, else -> DATA.
//   DATA : accept PMD_SIZE/IN_WIDTH beats, MSB first, into the word register.
//          After the last beat -> WRITE.
//   WRITE: exactly one cycle with host_ready=0, cslt=1, wrb=0,
//          add=PM_BASE+index (mod 2^PMA_SIZE), dt=word. Then:
//          checksum ^= word; index += 1;
//          index==count -> CHK, else -> DATA.
//   CHK  : accept one PMD_SIZE word. err = (word != checksum). Then -> DONE.
//   DONE : one cycle: done=1, busy=0, stallb=1 -> IDLE.
//  Outside WRITE: cslt=0, wrb=1. add and dt hold their last values.
//  Latency and stalls:
//   - PM write occurs exactly 1 cycle after the last beat of a word.
//   - host_valid gaps stall progress without losing state.
//  ld_start outside IDLE is ignored.
//  ld_start in the same cycle as reset: reset wins.
//  Address wrap past 2^PMA_SIZE-1 is silent (modulo).
//  count=2^PMA_SIZE-1 is legal.
// TESTING
//  (PMD_SIZE=32, PMA_SIZE=16, IN_WIDTH=8, PM_BASE=0)
//  1. Reset asserted 3 cycles mid-stream -> all outputs at reset values, FSM IDLE.
//  2. Clean load:
//     stream = start, 00 02, 11 22 33 44, AA BB CC DD, BB 99 FF 99
//     -> writes add0=0x11223344, add1=0xAABBCCDD.
//     -> done pulse 1 cycle after last checksum beat; err=0; stallb low throughout.
//  3. Same data, checksum 00 00 00 00 -> both words written, done pulses, err=1.
//     err clears on next ld_start.
//  4. count 00 00, checksum 00 00 00 00 -> no cslt pulses, done pulses, err=0.
//  5. Random host_valid gaps plus ld_start pulses while busy
//     -> PM writes and timing relative to accepted beats identical to test 2.
//  6. Reset in DATA after 2 beats of word 1 -> next cycle idle, stallb=1.
//     Then a fresh test-2 load succeeds.

Source files
------------

// File: rtl/pm_loader.sv
// pm_loader -- boot-time program-memory writer.
//
// Accepts a byte stream from a host over a valid/ready handshake. The stream is
// a header (word count), the data words, then one XOR checksum word. Every
// field is sent MSB-first. Each assembled word is written to consecutive PM
// addresses starting at PM_BASE. The core is held stalled for the whole load.
//
// Ports:
//   clk, reset   core clock, synchronous active-high reset
//   ld_start     begin a load (sampled only when idle)
//   host_dt      stream data, IN_WIDTH bits
//   host_valid   host_dt is valid
//   host_ready   loader accepts host_dt this cycle (registered)
//   ld_pm_cslt   PM chip select, 1 = access
//   ld_pm_wrb    PM write strobe, active-low
//   ld_pm_add    PM write address
//   ld_pm_dt     PM write data
//   ld_stallb    0 = core held in stall
//   ld_busy      load in progress
//   ld_done      one-cycle pulse at end of load
//   ld_err       checksum mismatch, sticky until next ld_start
module pm_loader #(
   parameter int PMA_SIZE = 16,
   parameter int PMD_SIZE = 32,
   parameter int IN_WIDTH = 8,
   parameter int PM_BASE  = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ld_start,
   input  logic [IN_WIDTH-1:0] host_dt,
   input  logic                host_valid,
   output logic                host_ready,
   output logic                ld_pm_cslt,
   output logic                ld_pm_wrb,
   output logic [PMA_SIZE-1:0] ld_pm_add,
   output logic [PMD_SIZE-1:0] ld_pm_dt,
   output logic                ld_stallb,
   output logic                ld_busy,
   output logic                ld_done,
   output logic                ld_err
);

   localparam int BEATS_A = PMA_SIZE / IN_WIDTH;
   localparam int BEATS_D = PMD_SIZE / IN_WIDTH;
   localparam int BMAX    = (BEATS_A > BEATS_D) ? BEATS_A : BEATS_D;
   localparam int BCW     = $clog2(BMAX + 1);

   localparam logic [BCW-1:0]      LAST_A = BCW'(BEATS_A - 1);
   localparam logic [BCW-1:0]      LAST_D = BCW'(BEATS_D - 1);
   localparam logic [PMA_SIZE-1:0] BASE   = PMA_SIZE'(PM_BASE);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HDR   = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] CHK   = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]          state, next_state;
   logic [PMA_SIZE-1:0] count, index, index_inc, count_sh;
   logic [PMD_SIZE-1:0] word, word_sh, checksum;
   logic [BCW-1:0]      beat;
   logic                accept, last_a, last_d, field_last;
   logic                ns_rx, ns_load;

   assign accept    = host_valid && host_ready;
   assign count_sh  = {count[PMA_SIZE-IN_WIDTH-1:0], host_dt};
   assign word_sh   = {word[PMD_SIZE-IN_WIDTH-1:0], host_dt};
   assign index_inc = index + 1'b1;
   assign last_a    = (beat == LAST_A);
   assign last_d    = (beat == LAST_D);
   assign field_last = (state == HDR) ? last_a : last_d;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (ld_start) next_state = HDR;
         HDR:   if (accept && last_a) next_state = (count_sh == '0) ? CHK : DATA;
         DATA:  if (accept && last_d) next_state = WRITE;
         WRITE: next_state = (index_inc == count) ? CHK : DATA;
         CHK:   if (accept && last_d) next_state = DONE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state
   // they describe rather than lagging it by a cycle.
   assign ns_rx   = (next_state == HDR) || (next_state == DATA) || (next_state == CHK);
   assign ns_load = ns_rx || (next_state == WRITE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         host_ready <= 1'b0;
         ld_pm_cslt <= 1'b0;
         ld_pm_wrb  <= 1'b1;
         ld_pm_add  <= '0;
         ld_pm_dt   <= '0;
         ld_stallb  <= 1'b1;
         ld_busy    <= 1'b0;
         ld_done    <= 1'b0;
         ld_err     <= 1'b0;
         count      <= '0;
         index      <= '0;
         word       <= '0;
         checksum   <= '0;
         beat       <= '0;
      end else begin
         state      <= next_state;
         host_ready <= ns_rx;
         ld_pm_cslt <= (next_state == WRITE);
         ld_pm_wrb  <= (next_state != WRITE);
         ld_busy    <= ns_load;
         ld_stallb  <= !ns_load;
         ld_done    <= (next_state == DONE);

         if (accept) beat <= field_last ? '0 : beat + 1'b1;

         case (state)
            IDLE: if (ld_start) begin
               ld_err   <= 1'b0;
               checksum <= '0;
               index    <= '0;
               count    <= '0;
               beat     <= '0;
            end
            HDR: if (accept) count <= count_sh;
            DATA: if (accept) begin
               word <= word_sh;
               // Address/data are loaded on the last beat so the write
               // strobe in WRITE already sees them.
               if (last_d) begin
                  ld_pm_add <= BASE + index;
                  ld_pm_dt  <= word_sh;
               end
            end
            WRITE: begin
               checksum <= checksum ^ word;
               index    <= index_inc;
            end
            CHK: if (accept) begin
               word <= word_sh;
               if (last_d) ld_err <= (word_sh != checksum);
            end
            default: ;
         endcase
      end
   end

endmodule
